// File: rtl/l2_line_sched.sv
// Line-transaction scheduler: arbitrates icache/dcache line requests onto a single
// L2 port and moves WORDS_PER_LINE beats per grant, one beat per cycle.
module l2_line_sched #(
  parameter int WORDS_PER_LINE = 4,
  parameter int RD_LATENCY     = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ic_req,
  input  logic        ic_wr,
  input  logic [31:0] ic_addr,
  input  logic [31:0] ic_wdata,
  output logic        ic_gnt,
  output logic        ic_wack,
  output logic [31:0] ic_rdata,
  output logic        ic_rvalid,
  output logic        ic_done,
  input  logic        dc_req,
  input  logic        dc_wr,
  input  logic [31:0] dc_addr,
  input  logic [31:0] dc_wdata,
  output logic        dc_gnt,
  output logic        dc_wack,
  output logic [31:0] dc_rdata,
  output logic        dc_rvalid,
  output logic        dc_done,
  output logic        l2_mem_en,
  output logic        l2_mem_wr_en,
  output logic [31:0] l2_mem_access_addr,
  output logic [31:0] l2_mem_wr_data,
  input  logic [31:0] l2_mem_rd_data
);

  localparam int          BEAT_W    = $clog2(WORDS_PER_LINE);
  localparam int          OFS_W     = BEAT_W + 2;
  localparam logic [31:0] BASE_MASK = ~((32'd1 << OFS_W) - 32'd1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;
  typedef enum logic {SRC_IC, SRC_DC} src_t;

  state_t                  state_q, state_d;
  src_t                    owner_q, last_q;
  logic                    wr_q;
  logic [31:0]             base_q;
  logic [BEAT_W-1:0]       beat_q;
  logic [RD_LATENCY-1:0]   pipe_vld_q, pipe_last_q;

  logic pick_dc, any_req, beat_last, rd_issue;
  logic rvalid, done, wack, busy;

  // Round-robin on a tie: whoever was not served last goes first.
  assign any_req   = ic_req || dc_req;
  assign pick_dc   = dc_req && (!ic_req || (last_q == SRC_IC));
  assign beat_last = (beat_q == BEAT_W'(WORDS_PER_LINE - 1));
  assign rd_issue  = (state_q == S_ISSUE) && !wr_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (any_req) state_d = S_ISSUE;
      S_ISSUE: if (beat_last) state_d = wr_q ? S_DONE : S_DRAIN;
      S_DRAIN: if (pipe_last_q[RD_LATENCY-1]) state_d = S_IDLE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: reset is synchronous here, so it lives inside the clocked branch, not the sensitivity list.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      owner_q     <= SRC_IC;
      last_q      <= SRC_DC;
      wr_q        <= 1'b0;
      base_q      <= '0;
      beat_q      <= '0;
      pipe_vld_q  <= '0;
      pipe_last_q <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      state_q     <= state_d;
      pipe_vld_q  <= RD_LATENCY'({pipe_vld_q, rd_issue});
      pipe_last_q <= RD_LATENCY'({pipe_last_q, rd_issue && beat_last});
      if ((state_q == S_IDLE) && any_req) begin
        owner_q <= pick_dc ? SRC_DC : SRC_IC;
        last_q  <= pick_dc ? SRC_DC : SRC_IC;
        wr_q    <= pick_dc ? dc_wr : ic_wr;
        base_q  <= (pick_dc ? dc_addr : ic_addr) & BASE_MASK;
        beat_q  <= '0;
      end else if (state_q == S_ISSUE) begin
        beat_q  <= beat_q + BEAT_W'(1);
      end
    end
  end

  // Returning read beats are tracked purely by the delay pipeline, so a reset
  // that clears it also suppresses beats already in flight to L2.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch behind.
    l2_mem_en          = 1'b0;
    l2_mem_wr_en       = 1'b0;
    l2_mem_access_addr = '0;
    l2_mem_wr_data     = '0;
    wack               = 1'b0;
    if (state_q == S_ISSUE) begin
      l2_mem_en          = 1'b1;
      l2_mem_access_addr = base_q + {{(32 - OFS_W){1'b0}}, beat_q, 2'b00};
      if (wr_q) begin
        l2_mem_wr_en   = 1'b1;
        l2_mem_wr_data = (owner_q == SRC_DC) ? dc_wdata : ic_wdata;
        wack           = 1'b1;
      end
    end
    busy   = (state_q != S_IDLE);
    rvalid = pipe_vld_q[RD_LATENCY-1];
    done   = (state_q == S_DONE) || ((state_q == S_DRAIN) && pipe_last_q[RD_LATENCY-1]);

    ic_gnt    = busy   && (owner_q == SRC_IC);
    ic_wack   = wack   && (owner_q == SRC_IC);
    ic_rvalid = rvalid && (owner_q == SRC_IC);
    ic_done   = done   && (owner_q == SRC_IC);
    ic_rdata  = ic_rvalid ? l2_mem_rd_data : '0;
    dc_gnt    = busy   && (owner_q == SRC_DC);
    dc_wack   = wack   && (owner_q == SRC_DC);
    dc_rvalid = rvalid && (owner_q == SRC_DC);
    dc_done   = done   && (owner_q == SRC_DC);
    dc_rdata  = dc_rvalid ? l2_mem_rd_data : '0;
  end

endmodule

// File: tb/tb_l2_line_sched.sv
// Bench for l2_line_sched: directed spec scenarios plus random line traffic, checked
// against a transaction-level timeline model and a shadow of L2 memory contents.
`timescale 1ns/1ps
module tb_l2_line_sched;
  localparam int W          = 4;
  localparam int L          = 1;
  localparam int LINE_BYTES = W * 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ic_req, ic_wr, dc_req, dc_wr;
  logic [31:0] ic_addr, ic_wdata, dc_addr, dc_wdata;
  logic        ic_gnt, ic_wack, ic_rvalid, ic_done;
  logic        dc_gnt, dc_wack, dc_rvalid, dc_done;
  logic [31:0] ic_rdata, dc_rdata;
  logic        l2_mem_en, l2_mem_wr_en;
  logic [31:0] l2_mem_access_addr, l2_mem_wr_data, l2_mem_rd_data;

  int checks = 0;
  int errors = 0;
  bit last_dc;
  logic [31:0] ic_wd0, dc_wd0;
  logic [31:0] exp_mem [logic [31:0]];
  logic [31:0] bus_mem [logic [31:0]];

  always #5 clk = ~clk;

  l2_line_sched #(.WORDS_PER_LINE(W), .RD_LATENCY(L)) dut (
    .clk(clk), .rst_n(rst_n),
    .ic_req(ic_req), .ic_wr(ic_wr), .ic_addr(ic_addr), .ic_wdata(ic_wdata),
    .ic_gnt(ic_gnt), .ic_wack(ic_wack), .ic_rdata(ic_rdata), .ic_rvalid(ic_rvalid), .ic_done(ic_done),
    .dc_req(dc_req), .dc_wr(dc_wr), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
    .dc_gnt(dc_gnt), .dc_wack(dc_wack), .dc_rdata(dc_rdata), .dc_rvalid(dc_rvalid), .dc_done(dc_done),
    .l2_mem_en(l2_mem_en), .l2_mem_wr_en(l2_mem_wr_en), .l2_mem_access_addr(l2_mem_access_addr),
    .l2_mem_wr_data(l2_mem_wr_data), .l2_mem_rd_data(l2_mem_rd_data)
  );

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, a[31:16] ^ 16'h1234};
  endfunction

  function automatic logic [31:0] exp_word(input logic [31:0] a);
    return exp_mem.exists(a) ? exp_mem[a] : init_word(a);
  endfunction

  function automatic bit arb_dc();
    return dc_req && (!ic_req || !last_dc);
  endfunction

  function automatic logic [159:0] all_outs();
    return {ic_gnt, ic_wack, ic_rvalid, ic_done, ic_rdata, dc_gnt, dc_wack, dc_rvalid, dc_done,
            dc_rdata, l2_mem_en, l2_mem_wr_en, l2_mem_access_addr, l2_mem_wr_data};
  endfunction

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // L2 behavioural memory: writes land, reads return RD_LATENCY cycles after issue,
  // and the data bus carries junk whenever no read beat is returning.
  logic        cap_rd = 1'b0, cap_wr = 1'b0;
  logic [31:0] cap_addr = '0, cap_wdata = '0;
  logic        rsp_vld  [L] = '{default: 1'b0};
  logic [31:0] rsp_addr [L] = '{default: 32'h0};

  always @(negedge clk) begin
    cap_rd    = l2_mem_en && !l2_mem_wr_en;
    cap_wr    = l2_mem_en && l2_mem_wr_en;
    cap_addr  = l2_mem_access_addr;
    cap_wdata = l2_mem_wr_data;
  end

  always @(posedge clk) begin
    #1;
    if (cap_wr) bus_mem[cap_addr] = cap_wdata;
    for (int i = L - 1; i > 0; i--) begin
      rsp_vld[i]  = rsp_vld[i-1];
      rsp_addr[i] = rsp_addr[i-1];
    end
    rsp_vld[0]  = cap_rd;
    rsp_addr[0] = cap_addr;
    if (rsp_vld[L-1])
      l2_mem_rd_data = bus_mem.exists(rsp_addr[L-1]) ? bus_mem[rsp_addr[L-1]] : init_word(rsp_addr[L-1]);
    else
      l2_mem_rd_data = $urandom;
  end

  // Walks one whole transaction from the grant wait to the idle cycle after done,
  // comparing every cycle against the timeline the rules imply.
  task automatic run_txn(input bit dc_win, input int drop_at, input bit release_req);
    bit          wr, en, rv;
    logic [31:0] base, wd0, a, rd;
    logic [35:0] win, los;
    int          n, last_c;
    wr   = dc_win ? dc_wr : ic_wr;
    a    = dc_win ? dc_addr : ic_addr;
    base = a & ~32'(LINE_BYTES - 1);
    wd0  = dc_win ? dc_wd0 : ic_wd0;
    if (dc_win) dc_wdata = wd0; else ic_wdata = wd0;
    n = 0;
    @(negedge clk);
    while (!l2_mem_en && n < 20) begin
      n++;
      @(negedge clk);
    end
    check("grant_latency", 160'(n), 160'(0));
    if (n >= 20) return;
    last_dc = dc_win;
    last_c  = wr ? W : W - 1 + L;
    for (int c = 0; c <= last_c + 1; c++) begin
      en = (c < W);
      rv = !wr && (c >= L) && (c - L < W);
      rd = rv ? exp_word(base + 32'(4 * (c - L))) : 32'h0;
      check($sformatf("l2_bus c=%0d", c),
            {l2_mem_en, l2_mem_wr_en, l2_mem_access_addr, l2_mem_wr_data},
            {en, en && wr, en ? base + 32'(4 * c) : 32'h0, (en && wr) ? wd0 + 32'(c) : 32'h0});
      win = dc_win ? {dc_gnt, dc_wack, dc_rvalid, dc_done, dc_rdata}
                   : {ic_gnt, ic_wack, ic_rvalid, ic_done, ic_rdata};
      los = dc_win ? {ic_gnt, ic_wack, ic_rvalid, ic_done, ic_rdata}
                   : {dc_gnt, dc_wack, dc_rvalid, dc_done, dc_rdata};
      check($sformatf("winner c=%0d dc=%0d", c, dc_win), 160'(win),
            160'({c <= last_c, en && wr, rv, c == last_c, rd}));
      check($sformatf("loser c=%0d", c), 160'(los), 160'(0));
      if (en && wr) exp_mem[base + 32'(4 * c)] = wd0 + 32'(c);
      if (c <= last_c) begin
        @(posedge clk);
        #1;
        if (dc_win) dc_wdata = wd0 + 32'(c + 1); else ic_wdata = wd0 + 32'(c + 1);
        if (c == drop_at || (c == last_c && release_req)) begin
          if (dc_win) dc_req = 1'b0; else ic_req = 1'b0;
        end
        @(negedge clk);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; ic_req = 1'b0; dc_req = 1'b0; ic_wr = 1'b0; dc_wr = 1'b0;
    ic_addr = '0; dc_addr = '0; ic_wdata = '0; dc_wdata = '0; ic_wd0 = '0; dc_wd0 = '0;
    last_dc = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", all_outs(), 160'(0));
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("idle_after_reset", all_outs(), 160'(0));

    // Tie straight after reset: icache, then dcache write, then icache reads it back.
    ic_wr = 1'b0; ic_addr = 32'h0000_104C;
    dc_wr = 1'b1; dc_addr = 32'h0000_2000; dc_wd0 = 32'hA0;
    ic_req = 1'b1; dc_req = 1'b1;
    run_txn(1'b0, -1, 1'b0);
    ic_addr = 32'h0000_2008;
    run_txn(1'b1, -1, 1'b1);
    run_txn(1'b0, -1, 1'b1);

    // dcache read with request dropped after the second beat.
    dc_wr = 1'b0; dc_addr = 32'h0000_3014; dc_req = 1'b1;
    run_txn(1'b1, 1, 1'b1);

    // Top-of-memory lines: read and write.
    ic_wr = 1'b0; ic_addr = 32'hFFFF_FFF0; ic_req = 1'b1;
    run_txn(1'b0, -1, 1'b1);
    dc_wr = 1'b1; dc_addr = 32'hFFFF_FFF8; dc_wd0 = 32'hDEAD_0000; dc_req = 1'b1;
    run_txn(1'b1, -1, 1'b1);
    ic_addr = 32'hFFFF_FFFC; ic_req = 1'b1;
    run_txn(1'b0, -1, 1'b1);

    // Reset in the second beat of an icache read aborts it completely.
    ic_wr = 1'b0; ic_addr = 32'h0000_104C; ic_req = 1'b1;
    @(negedge clk);
    check("abort_beat0", {ic_gnt, l2_mem_en, l2_mem_access_addr}, {2'b11, 32'h0000_1040});
    @(negedge clk);
    check("abort_beat1", {ic_gnt, l2_mem_en, l2_mem_access_addr}, {2'b11, 32'h0000_1044});
    rst_n = 1'b0; ic_req = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("abort_outputs_zero", all_outs(), 160'(0));
    last_dc = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("abort_quiet %0d", i), {ic_gnt, ic_rvalid, ic_done, l2_mem_en}, 4'b0000);
    end
    dc_wr = 1'b0; dc_addr = 32'h0000_1040; dc_req = 1'b1;
    run_txn(1'b1, -1, 1'b1);

    // Random traffic on a small address window so writes and reads share lines.
    for (int it = 0; it < 16; it++) begin
      logic [1:0] who;
      int         drop;
      who     = 2'($urandom_range(1, 3));
      ic_wr   = 1'($urandom);
      dc_wr   = 1'($urandom);
      ic_addr = 32'h0000_4000 + ($urandom & 32'h7F);
      dc_addr = 32'h0000_4000 + ($urandom & 32'h7F);
      ic_wd0  = $urandom;
      dc_wd0  = $urandom;
      ic_req  = who[0];
      dc_req  = who[1];
      drop    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, W - 1)) : -1;
      run_txn(arb_dc(), drop, 1'b1);
      if (ic_req || dc_req) run_txn(arb_dc(), -1, 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "simulation time limit reached");
  end

endmodule

// File: doc/l2_line_sched.md
L2_LINE_SCHED -- requirements
Module: l2_line_sched

Interface
REQ-001 Parameter WORDS_PER_LINE, default 4: 32-bit beats per line transaction; power of two, 2..16.
REQ-002 Parameter RD_LATENCY, default 1: cycles from an L2 read beat issue (l2_mem_en=1, l2_mem_wr_en=0) to valid l2_mem_rd_data; 1..4.
REQ-003 clk  in  1  clock; all state updates on the rising edge.
REQ-004 rst_n  in  1  reset, synchronous, active-low.
REQ-005 ic_req / dc_req  in  1  icache / dcache line request; held high until the matching done pulse.
REQ-006 ic_wr / dc_wr  in  1  1 = line write (writeback), 0 = line fill; sampled at grant.
REQ-007 ic_addr / dc_addr  in  32  byte address inside the line; sampled at grant.
REQ-008 ic_wdata / dc_wdata  in  32  write beat data; must be valid in the cycle its wack is high.
REQ-009 ic_gnt / dc_gnt  out  1  high for the whole transaction, from the first issue beat through the done cycle.
REQ-010 ic_wack / dc_wack  out  1  write beat consumed this cycle; requester advances wdata next cycle.
REQ-011 ic_rdata / dc_rdata  out  32  read beat data; 0 when the matching rvalid is low.
REQ-012 ic_rvalid / dc_rvalid  out  1  read beat valid, in ascending beat order.
REQ-013 ic_done / dc_done  out  1  one-cycle pulse marking transaction end.
REQ-014 l2_mem_en, l2_mem_wr_en  out  1 each  L2 port enable / write enable.
REQ-015 l2_mem_access_addr, l2_mem_wr_data  out  32 each  L2 port address / write data.
REQ-016 l2_mem_rd_data  in  32  L2 port read data.

Function
REQ-017 FSM states: IDLE, ISSUE, DRAIN, DONE.
REQ-018 IDLE: with any request high, register the winner, line base = addr with bits [log2(WORDS_PER_LINE)+1:0] cleared, beat counter = 0; go to ISSUE.
REQ-019 Arbitration: single request wins; both high -> the requester not served last wins; last-served pointer resets to dcache, so icache wins the first tie.
REQ-020 ISSUE: one beat per cycle; l2_mem_en=1; l2_mem_access_addr = base + 4*beat; beat counter +1; after beat WORDS_PER_LINE-1 go to DRAIN (reads) or DONE (writes).
REQ-021 Write beats: l2_mem_wr_en=1, l2_mem_wr_data = winner wdata, winner wack=1 in the same cycle.
REQ-022 Read beats: l2_mem_wr_en=0, l2_mem_wr_data=0; delay-tracking pipeline of depth RD_LATENCY marks returning beats; winner rvalid=1 and rdata=l2_mem_rd_data exactly RD_LATENCY cycles after each issue.
REQ-023 DRAIN: l2_mem_en=0; leave when the last beat's rvalid is produced; done pulses in that same cycle; then IDLE.
REQ-024 DONE (writes): l2_mem_en=0; done pulses one cycle; then IDLE.
REQ-025 Address increment wraps within 32 bits; no carry into the line base is possible because base is aligned.
REQ-026 Request deassertion mid-transaction is ignored; the transaction completes and done still pulses.
REQ-027 A request arriving during a transaction waits; arbitration happens only in IDLE, one IDLE cycle minimum between transactions.
REQ-028 Outside ISSUE, l2_mem_en, l2_mem_wr_en, l2_mem_access_addr and l2_mem_wr_data are 0; the loser's gnt, wack, rvalid, rdata and done are 0.
REQ-029 The last-served pointer updates at grant (IDLE->ISSUE).

Reset
REQ-030 rst_n low at any clock edge: FSM to IDLE, beat counter 0, delay pipeline cleared, last-served = dcache; all outputs 0 in the cycle after that edge.
REQ-031 Reset mid-transaction aborts the transaction: no done pulse, no further rvalid, even for beats already in flight to L2.

Verification (WORDS_PER_LINE=4, RD_LATENCY=1)
REQ-032 ic_req=1, ic_wr=0, ic_addr=0x0000_104C -> L2 reads 0x1040, 0x1044, 0x1048, 0x104C on 4 consecutive cycles; ic_rvalid one cycle after each; ic_done with the 4th rvalid.
REQ-033 dc_req=1, dc_wr=1, dc_addr=0x2000, wdata 0xA0..0xA3 -> l2_mem_wr_en=1 for 4 cycles, data 0xA0..0xA3 to 0x2000..0x200C; dc_wack 4 cycles; dc_done the cycle after.
REQ-034 ic_req and dc_req rise together after reset, both held -> icache line first, then dcache, then icache; gnt never overlaps.
REQ-035 dc_req dropped after the 2nd read beat -> all 4 beats issued and returned; dc_done pulses.
REQ-036 rst_n low in cycle 2 of an icache read -> next cycle all outputs 0, no ic_rvalid or ic_done afterwards; a fresh dcache request then completes normally.
REQ-037 ic_addr=0xFFFF_FFF0 read -> addresses 0xFFFF_FFF0..0xFFFF_FFFC, no wrap corruption.
